// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register for the pipelined LC-3b core.
// Define FETCH_PERF_EN to add the perf_fetched / perf_bubbles counters.
package fetch_pkg;
  typedef logic [15:0] lc3b_word;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_read,
  output logic [15:0] icache_address,
  input  logic [15:0] icache_rdata,
  input  logic        icache_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output lc3b_word    if_ir,
  output logic [15:0] if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t      state, state_d;
  logic [15:0] pc_reg, pend_pc, hold_pc, pc_inc;
  lc3b_word    hold_ir;
  logic        load;
  lc3b_word    load_ir;
  logic [15:0] load_pc;

  assign pc_inc = pc_reg + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_REQ: begin
        if (icache_resp) begin
          if (!redirect && stall) state_d = S_HOLD;
        end else if (redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD:  if (redirect || !stall) state_d = S_REQ;
      S_DRAIN: if (icache_resp) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  // A load into IF/ID happens either straight from the cache or from the hold buffer.
  always_comb begin
    icache_read    = 1'b0;
    icache_address = pc_reg;
    load           = 1'b0;
    load_ir        = hold_ir;
    load_pc        = hold_pc;
    case (state)
      S_REQ: begin
        icache_read = !rst;
        if (icache_resp && !redirect && !stall) begin
          load    = 1'b1;
          load_ir = icache_rdata;
          load_pc = pc_inc;
        end
      end
      S_HOLD:  load = !redirect && !stall;
      S_DRAIN: icache_read = !rst;
      default: icache_read = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg  <= RESET_PC;
      pend_pc <= 16'h0000;
      hold_ir <= 16'h0000;
      hold_pc <= 16'h0000;
    end else begin
      case (state)
        S_REQ: begin
          if (icache_resp) begin
            if (redirect) begin
              pc_reg <= redirect_pc;
            end else begin
              pc_reg <= pc_inc;
              if (stall) begin
                hold_ir <= icache_rdata;
                hold_pc <= pc_inc;
              end
            end
          end else if (redirect) begin
            pend_pc <= redirect_pc;
          end
        end
        S_HOLD: if (redirect) pc_reg <= redirect_pc;
        S_DRAIN: begin
          // A redirect coinciding with the drain response is newer than pend_pc.
          if (icache_resp)   pc_reg  <= redirect ? redirect_pc : pend_pc;
          else if (redirect) pend_pc <= redirect_pc;
        end
        default: pc_reg <= pc_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_ir    <= 16'h0000;
      if_pc    <= 16'h0000;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_valid <= load;
      if (load) begin
        if_ir <= load_ir;
        if_pc <= load_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble;
  assign bubble = !stall && !load;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else begin
      if (load && perf_fetched != 32'hFFFF_FFFF)   perf_fetched <= perf_fetched + 32'd1;
      if (bubble && perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect/reset
// traffic, checked against an event-level model and a latency-programmable cache.
module tb_fetch_stage;
  localparam logic [15:0] RPC = 16'h0040;

  logic        clk = 1'b0;
  logic        rst, icache_read, icache_resp, stall, redirect, if_valid;
  logic [15:0] icache_address, icache_rdata, redirect_pc, if_ir, if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;

  // reference model
  logic [15:0] m_pc, m_pend, m_hir, m_hpc, m_ir, m_ifpc;
  bit          m_hold, m_drain, m_v;
  logic [31:0] m_fet, m_bub;

  // cache model
  bit          c_busy = 1'b0;
  int          c_left = 0, lat = 1;
  logic [15:0] c_addr = 16'h0000;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C ^ {a[14:0], 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit rd, input logic [15:0] rpc,
                              input bit resp, input logic [15:0] rdata);
    bit ld;
    logic [15:0] lw, lp;
    ld = 1'b0; lw = 16'h0; lp = 16'h0;
    if (r) begin
      m_pc = RPC; m_pend = 0; m_hir = 0; m_hpc = 0; m_hold = 0; m_drain = 0;
      m_v = 0; m_ir = 0; m_ifpc = 0; m_fet = 0; m_bub = 0;
      return;
    end
    if (m_drain) begin
      if (resp) begin m_pc = rd ? rpc : m_pend; m_drain = 0; end
      else if (rd) m_pend = rpc;
    end else if (m_hold) begin
      if (rd) begin m_pc = rpc; m_hold = 0; end
      else if (!s) begin ld = 1; lw = m_hir; lp = m_hpc; m_hold = 0; end
    end else begin
      if (resp) begin
        if (rd) m_pc = rpc;
        else if (!s) begin ld = 1; lw = rdata; lp = m_pc + 16'd2; m_pc = m_pc + 16'd2; end
        else begin m_hir = rdata; m_hpc = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_hold = 1; end
      end else if (rd) begin
        m_pend = rpc; m_drain = 1;
      end
    end
    if (rd) m_v = 0;
    else if (!s) begin
      m_v = ld;
      if (ld) begin m_ir = lw; m_ifpc = lp; end
    end
    if (ld && m_fet != 32'hFFFF_FFFF) m_fet++;
    if (!s && !ld && m_bub != 32'hFFFF_FFFF) m_bub++;
  endtask

  // One clock cycle: drive inputs, check outputs, run the cache, advance the model.
  task automatic step(input bit r, input bit s, input bit rd, input logic [15:0] rpc);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    if (chk_en) begin
      chk("icache_read", {31'd0, icache_read}, {31'd0, !r && !m_hold});
      chk("icache_address", {16'd0, icache_address}, {16'd0, m_pc});
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
      if (m_v) begin
        chk("if_ir", {16'd0, if_ir}, {16'd0, m_ir});
        chk("if_pc", {16'd0, if_pc}, {16'd0, m_ifpc});
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fet);
      chk("perf_bubbles", perf_bubbles, m_bub);
`endif
      if (c_busy && !r)
        chk("read_held_stable", {15'd0, icache_read, icache_address}, {15'd0, 1'b1, c_addr});
    end
    icache_resp = 1'b0;
    icache_rdata = 16'($urandom);
    if (r) c_busy = 1'b0;
    else begin
      if (icache_read && !c_busy) begin c_busy = 1'b1; c_left = lat; c_addr = icache_address; end
      if (c_busy) begin
        if (c_left == 0) begin icache_resp = 1'b1; icache_rdata = mem(c_addr); c_busy = 1'b0; end
        else c_left--;
      end
    end
    #1;
    model_update(r, s, rd, rpc, icache_resp, icache_rdata);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; icache_resp = 0; icache_rdata = 0;
    m_pc = 0; m_pend = 0; m_hir = 0; m_hpc = 0; m_ir = 0; m_ifpc = 0;
    m_hold = 0; m_drain = 0; m_v = 0; m_fet = 0; m_bub = 0;

    step(1, 0, 0, 16'h0);
    chk_en = 1'b1;
    step(1, 0, 0, 16'h0);
    chk("rst_read", {31'd0, icache_read}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ir", {16'd0, if_ir}, 32'd0);
    chk("rst_pc", {16'd0, if_pc}, 32'd0);
    chk("rst_addr", {16'd0, icache_address}, {16'd0, RPC});

    // 1-cycle cache from RESET_PC
    lat = 1;
    step(0, 0, 0, 16'h0);
    chk("first_req", {15'd0, icache_read, icache_address}, {15'd0, 1'b1, 16'h0040});
    step(0, 0, 0, 16'h0);
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_ir", {16'd0, if_ir}, {16'd0, mem(16'h0040)});
    chk("first_pc", {16'd0, if_pc}, 32'h0042);
    chk("second_addr", {16'd0, icache_address}, 32'h0042);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("third_addr", {16'd0, icache_address}, 32'h0044);
    chk("second_ir", {16'd0, if_ir}, {16'd0, mem(16'h0042)});

    // stall across a response
    repeat (4) step(0, 1, 0, 16'h0);
    chk("hold_read", {31'd0, icache_read}, 32'd0);
    chk("hold_ir", {16'd0, if_ir}, {16'd0, mem(16'h0042)});
    step(0, 0, 0, 16'h0);
    chk("unhold_valid", {31'd0, if_valid}, 32'd1);
    chk("unhold_ir", {16'd0, if_ir}, {16'd0, mem(16'h0044)});
    chk("unhold_pc", {16'd0, if_pc}, 32'h0046);
    chk("unhold_addr", {15'd0, icache_read, icache_address}, {15'd0, 1'b1, 16'h0046});

    // redirect into a 4-cycle read at 0010
    step(0, 0, 1, 16'h0010);
    step(0, 0, 0, 16'h0);
    chk("redir_addr", {15'd0, icache_read, icache_address}, {15'd0, 1'b1, 16'h0010});
    lat = 4;
    step(0, 0, 1, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", {15'd0, icache_read, icache_address}, {15'd0, 1'b1, 16'h0010});
      chk("drain_valid", {31'd0, if_valid}, 32'd0);
      step(0, 0, 0, 16'h0);
    end
    chk("after_drain_addr", {16'd0, icache_address}, 32'h0100);
    chk("after_drain_valid", {31'd0, if_valid}, 32'd0);

    // redirect coinciding with response
    lat = 1;
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0200);
    chk("same_cyc_addr", {15'd0, icache_read, icache_address}, {15'd0, 1'b1, 16'h0200});
    chk("same_cyc_valid", {31'd0, if_valid}, 32'd0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("tgt_ir", {16'd0, if_ir}, {16'd0, mem(16'h0200)});
    chk("tgt_pc", {16'd0, if_pc}, 32'h0202);

    // reset while draining
    lat = 3;
    step(0, 0, 1, 16'h0300);
    step(0, 0, 0, 16'h0);
    lat = 1;
    step(1, 0, 0, 16'h0);
    chk("rst_drain_addr", {16'd0, icache_address}, {16'd0, RPC});
    chk("rst_drain_valid", {31'd0, if_valid}, 32'd0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("post_rst_ir", {16'd0, if_ir}, {16'd0, mem(16'h0040)});
    chk("post_rst_pc", {16'd0, if_pc}, 32'h0042);

    // PC wrap at FFFE
    step(0, 0, 1, 16'hFFFE);
    step(0, 0, 0, 16'h0);
    chk("wrap_req", {16'd0, icache_address}, 32'hFFFE);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("wrap_addr", {16'd0, icache_address}, 32'h0000);
    chk("wrap_pc", {16'd0, if_pc}, 32'h0000);
    chk("wrap_ir", {16'd0, if_ir}, {16'd0, mem(16'hFFFE)});

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, s, rd;
      logic [15:0] t;
      lat = $urandom_range(1, 3);
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 8);
      t   = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      step(r, s, rd, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
